module_disp_scheduler: RTL and testbench

Time-multiplexed scan controller that shares one set of 7-segment lines among N_DIGITS common-anode digits. It decodes per-digit hex nibbles and sequences the anodes with a dead-time gap between digits. When the decoder's bit_error flag is high, it overrides the most-significant digit with the error glyph. It sits between the Hamming decode/error datapath and the board's segment/anode pins, replacing direct per-digit drive.

---
 rtl/module_disp_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_module_disp_scheduler.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/module_disp_scheduler.sv
// rtl/module_disp_scheduler.sv - multiplexed 7-segment scan controller with dead time and error glyph
// Optional blinking of the whole display on error: define ERROR_BLINK_EN.
module module_disp_scheduler #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 27000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_TICKS  = 250
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [4*N_DIGITS-1:0]       digits_i,
  input  logic [N_DIGITS-1:0]         digit_en_i,
  input  logic                        bit_error_i,
  output logic [6:0]                  seg_o,
  output logic [N_DIGITS-1:0]         an_o,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx_o,
  output logic                        tick_o
);

  localparam int IW      = $clog2(N_DIGITS);
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  if (N_DIGITS < 2 || N_DIGITS > 8 || REFRESH_DIV < 2 || BLANK_CYCLES < 0 || BLINK_TICKS < 1)
  begin : g_bad_params
    $error("module_disp_scheduler: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, idx_next;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tick_d;
  logic            load;
  logic [3:0]      nib_q, nib_d;
  logic            en_q, en_d;
  logic            err_q, err_d;
  logic            phase_d;
  logic [6:0]      seg_d;
  logic [N_DIGITS-1:0] an_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign idx_next = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    tick_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = SHOW;
        idx_d   = '0;
        cnt_d   = '0;
        tick_d  = 1'b1;
        load    = 1'b1;
      end
      SHOW: begin
        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
          cnt_d = '0;
          if (BLANK_CYCLES == 0) begin
            idx_d  = idx_next;
            tick_d = 1'b1;
            load   = 1'b1;
          end else begin
            state_d = BLANK;
          end
        end
      end
      BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = SHOW;
          idx_d   = idx_next;
          cnt_d   = '0;
          tick_d  = 1'b1;
          load    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Slot registers capture the inputs only on SHOW entry; the view below is what the slot will hold.
  assign nib_d = load ? digits_i[4*idx_d +: 4] : nib_q;
  assign en_d  = load ? digit_en_i[idx_d]      : en_q;
  assign err_d = load ? bit_error_i            : err_q;

`ifdef ERROR_BLINK_EN
  localparam int BW = $clog2(BLINK_TICKS + 1);
  logic          phase_q;
  logic [BW-1:0] bcnt_q, bcnt_d;

  always_comb begin
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    if (load) begin
      if (!bit_error_i) begin
        phase_d = 1'b1;
        bcnt_d  = '0;
      end else if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
        phase_d = ~phase_q;
        bcnt_d  = '0;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= 1'b1;
      bcnt_q  <= '0;
    end else begin
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
    end
  end
`else
  assign phase_d = 1'b1;
`endif

  always_comb begin
    seg_d = 7'h7F;
    an_d  = '1;
    if (state_d == SHOW) begin
      seg_d = hex7(nib_d);
      if (en_d) an_d[idx_d] = 1'b0;
      if (idx_d == IW'(N_DIGITS - 1) && err_d) begin
        seg_d       = 7'b0000110;
        an_d[idx_d] = 1'b0;
      end
      if (!phase_d) an_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tick_o  <= 1'b0;
      seg_o   <= 7'h7F;
      an_o    <= '1;
      nib_q   <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tick_o  <= tick_d;
      seg_o   <= seg_d;
      an_o    <= an_d;
      nib_q   <= nib_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  assign digit_idx_o = idx_q;

endmodule

// File: tb/tb_module_disp_scheduler.sv
// tb/tb_module_disp_scheduler.sv - randomized scoreboard bench for module_disp_scheduler
module tb_module_disp_scheduler;
  localparam int N  = 4;
  localparam int R  = 4;
  localparam int B  = 2;
  localparam int BT = 4;
  localparam int P  = R + B;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  digits_i;
  logic [3:0]   digit_en_i;
  logic         bit_error_i;
  logic [6:0]   seg_o;
  logic [3:0]   an_o;
  logic [1:0]   digit_idx_o;
  logic         tick_o;

  int total = 0;
  int bad   = 0;

  module_disp_scheduler #(
    .N_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .BLINK_TICKS(BT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .digit_en_i(digit_en_i),
    .bit_error_i(bit_error_i), .seg_o(seg_o), .an_o(an_o),
    .digit_idx_o(digit_idx_o), .tick_o(tick_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
    seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110;
    seg_tab[15] = 7'b0001110;
  end

  // Reference: position in the frame follows purely from cycles elapsed since reset release.
  int         t = -1;
  int         w, mi, mbcnt;
  logic [3:0] mnib;
  logic       men, merr, mphase, lit;
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic [1:0] exp_idx;
  logic       exp_tick;
  logic       started = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      t = -1; exp_seg = 7'h7F; exp_an = 4'hF; exp_idx = 2'd0; exp_tick = 1'b0;
      mphase = 1'b1; mbcnt = 0;
    end else begin
      t++;
      w  = t % P;
      mi = (t / P) % N;
      exp_idx  = 2'(mi);
      exp_tick = (w == 0);
      if (w == 0) begin
        mnib = digits_i[4*mi +: 4];
        men  = digit_en_i[mi];
        merr = bit_error_i;
`ifdef ERROR_BLINK_EN
        if (merr) begin
          mbcnt++;
          if (mbcnt == BT) begin mbcnt = 0; mphase = !mphase; end
        end else begin
          mphase = 1'b1; mbcnt = 0;
        end
`endif
      end
      if (w < R) begin
        lit     = men || (mi == N - 1 && merr);
        exp_seg = (mi == N - 1 && merr) ? 7'b0000110 : seg_tab[mnib];
        exp_an  = (lit && mphase) ? ~(4'b0001 << mi) : 4'hF;
      end else begin
        exp_seg = 7'h7F; exp_an = 4'hF;
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("seg", 32'(seg_o), 32'(exp_seg));
      chk("an", 32'(an_o), 32'(exp_an));
      chk("idx", 32'(digit_idx_o), 32'(exp_idx));
      chk("tick", 32'(tick_o), 32'(exp_tick));
    end
  end

  initial begin
    rst_n = 1'b0; digits_i = 16'h1234; digit_en_i = 4'hF; bit_error_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("lit_rst_an", 32'(an_o), 32'h0F);
    chk("lit_rst_seg", 32'(seg_o), 32'h7F);
    chk("lit_rst_idx", 32'(digit_idx_o), 32'h0);
    chk("lit_rst_tick", 32'(tick_o), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_first_tick", 32'(tick_o), 32'h1);
    chk("lit_first_an", 32'(an_o), 32'h0E);
    chk("lit_first_seg", 32'(seg_o), 32'(7'b0011001));
    repeat (4) @(negedge clk);
    chk("lit_blank_an", 32'(an_o), 32'h0F);
    chk("lit_blank_seg", 32'(seg_o), 32'h7F);
    repeat (2) @(negedge clk);
    chk("lit_slot1_an", 32'(an_o), 32'h0D);
    chk("lit_slot1_seg", 32'(seg_o), 32'(7'b0110000));
    chk("lit_slot1_tick", 32'(tick_o), 32'h1);
    digit_en_i = 4'b1010;
    repeat (6) @(negedge clk);
    chk("lit_slot2_dis_an", 32'(an_o), 32'h0F);
    chk("lit_slot2_idx", 32'(digit_idx_o), 32'h2);
    repeat (6) @(negedge clk);
    chk("lit_slot3_an", 32'(an_o), 32'h07);
    chk("lit_slot3_seg", 32'(seg_o), 32'(7'b1111001));
    bit_error_i = 1'b1; digit_en_i = 4'b0111;
    repeat (24) @(negedge clk);
`ifndef ERROR_BLINK_EN
    chk("lit_err_seg", 32'(seg_o), 32'(7'b0000110));
    chk("lit_err_an", 32'(an_o), 32'h07);
`endif
    bit_error_i = 1'b0;
    @(negedge clk);
`ifndef ERROR_BLINK_EN
    chk("lit_err_hold_seg", 32'(seg_o), 32'(7'b0000110));
`endif
    bit_error_i = 1'b1;
    repeat (18) @(negedge clk);
    chk("lit_pre_rst_idx", 32'(digit_idx_o), 32'h2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("lit_mid_rst_an", 32'(an_o), 32'h0F);
    chk("lit_mid_rst_idx", 32'(digit_idx_o), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_resume_an", 32'(an_o), 32'h0E);
    chk("lit_resume_tick", 32'(tick_o), 32'h1);
    repeat (120) @(negedge clk);
    bit_error_i = 1'b0;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) digits_i = 16'($urandom);
      if ($urandom_range(0, 7) == 0) digit_en_i = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bit_error_i = ~bit_error_i;
      rst_n = ($urandom_range(0, 199) != 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
